// File: rtl/div_unit.sv
// div_unit: iterative restoring radix-2 divider for the EX stage.
// Produces one quotient bit per cycle, DATA_W cycles per divide, and holds the
// pipeline via stallreq_for_ex until the result is ready.
//
// Ports:
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   start_i          divide requested this cycle
//   signed_i         1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i        dividend
//   opdata2_i        divisor
//   annul_i          cancel the in-flight operation
//   result_o         {remainder, quotient}
//   ready_o          result_o valid (END state)
//   stallreq_for_ex  stall request to the pipeline controller
module div_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_for_ex
);

  localparam int unsigned CntW = $clog2(DATA_W);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StByZero = 2'd1;
  localparam logic [1:0] StOn     = 2'd2;
  localparam logic [1:0] StEnd    = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;   // dividend magnitude, shifted out MSB first
  logic [DATA_W-1:0]   dsr_q, dsr_d;   // divisor magnitude
  logic [DATA_W-1:0]   rem_q, rem_d;   // partial remainder
  logic [DATA_W-1:0]   quo_q, quo_d;   // quotient bits collected so far
  logic                neg1_q, neg1_d; // dividend was negative (signed mode)
  logic                neg2_q, neg2_d; // divisor was negative (signed mode)
  logic [2*DATA_W-1:0] result_q, result_d;

  // One restoring step. The trial value needs DATA_W+1 bits because the
  // shifted partial remainder can exceed the largest DATA_W-bit divisor.
  logic [DATA_W:0]   trial;
  logic [DATA_W:0]   diff;
  logic              qbit;
  logic [DATA_W-1:0] rem_step;
  logic [DATA_W-1:0] quo_step;
  logic [DATA_W-1:0] rem_fix;
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] op1_mag;
  logic [DATA_W-1:0] op2_mag;

  always_comb begin
    trial    = {rem_q, dvd_q[DATA_W-1]};
    diff     = trial - {1'b0, dsr_q};
    qbit     = ~diff[DATA_W];
    rem_step = qbit ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
    quo_step = {quo_q[DATA_W-2:0], qbit};
    // -2^31 / -1 falls out naturally: magnitude quotient 2^31, no negation.
    quo_fix  = (neg1_q ^ neg2_q) ? -quo_step : quo_step;
    rem_fix  = neg1_q ? -rem_step : rem_step;
    op1_mag  = (signed_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    op2_mag  = (signed_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = StByZero;
          end else begin
            state_d = StOn;
            cnt_d   = '0;
            dvd_d   = op1_mag;
            dsr_d   = op2_mag;
            rem_d   = '0;
            quo_d   = '0;
            neg1_d  = signed_i & opdata1_i[DATA_W-1];
            neg2_d  = signed_i & opdata2_i[DATA_W-1];
          end
        end
      end
      StByZero: begin
        result_d = '0;
        state_d  = StEnd;
      end
      StOn: begin
        if (annul_i) begin
          state_d = StIdle;
        end else begin
          dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(DATA_W - 1)) begin
            result_d = {rem_fix, quo_fix};
            state_d  = StEnd;
          end
        end
      end
      StEnd: begin
        if (annul_i || !start_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = (state_q == StEnd);
  // Released in END so EX advances with the result that cycle.
  assign stallreq_for_ex = !rst &&
                           (((state_q == StIdle) && start_i && !annul_i) ||
                            (state_q == StOn) || (state_q == StByZero));

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit signed/unsigned divider living in the EX stage.
- It is the requesting end of the pipeline stall handshake: it drives stallreq_for_ex high for the whole time a division is in flight. The pipeline controller answers by freezing IF/ID/EX, and the divider drops the request once the result is ready.
- Restoring radix-2 algorithm: one quotient bit per cycle.

Parameters:
- DATA_W, 32, operand width. Result is 2*DATA_W bits; the iteration count equals DATA_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  EX requests a division this cycle (DIV/DIVU decoded).
- signed_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU).
- opdata1_i  input  DATA_W  dividend.
- opdata2_i  input  DATA_W  divisor.
- annul_i  input  1  cancel the in-flight operation (exception/flush).
- result_o  output  2*DATA_W  {remainder, quotient}: [63:32] = HI, [31:0] = LO.
- ready_o  output  1  result_o valid.
- stallreq_for_ex  output  1  stall request to the pipeline controller.

Behaviour:
- Reset (rst=1 at a clock edge, also mid-operation): state=IDLE, counter=0, result_o=0, ready_o=0. stallreq_for_ex=0 whenever rst=1.
- States: IDLE, BYZERO, ON, END (2-bit encoding).
- IDLE:
  - If start_i=1 and annul_i=0:
    - divisor==0 -> BYZERO.
    - otherwise latch operands -> ON, counter=0.
  - In signed mode, latch magnitudes: operand negated if its MSB=1. Also latch both original sign bits.
  - Otherwise stay in IDLE.
- BYZERO: result = 64'h0 -> END next cycle.
- ON: one restoring step per cycle.
  - Partial remainder shifts left and takes the next dividend bit.
  - If partial >= divisor: subtract and set the quotient bit to 1; else the quotient bit is 0.
  - counter increments.
  - After the 32nd step (counter==31 at the edge), apply sign correction and go to END.
  - annul_i=1 in ON -> IDLE immediately; partial result discarded; ready_o stays 0.
- Signed correction:
  - Quotient negated if the dividend and divisor signs differ.
  - Remainder negated if the dividend is negative.
  - Overflow case -2^31 / -1: quotient 32'h80000000, remainder 0. Wraps, no trap.
- END: ready_o=1, result_o holds the registered result. Stay in END while start_i=1; go to IDLE (ready_o=0) the cycle after start_i=0. annul_i in END -> IDLE.
- Latency, start accepted at edge T:
  - Normal: ON during cycles T+1..T+32; END/ready_o=1 from T+33.
  - Divide-by-zero: ready_o=1 from T+2.
- stallreq_for_ex is combinational and equals 1 in any of these cases:
  - (IDLE and start_i and !annul_i)
  - ON
  - BYZERO
  - It is 0 in END and otherwise, so EX advances with the result in the END cycle.
- While stalled, the pipeline holds start_i and the operands stable. Operand changes during ON are ignored because the operands were latched.
- ready_o is never high outside END. result_o only changes when END is entered or on reset.
- Back-to-back divides: a new start is accepted only after returning to IDLE, which requires at least one cycle with start_i=0.

Test Plan:
- Unsigned: start with op1=100, op2=7, signed=0 -> stallreq high cycles T..T+32, ready at T+33, result_o={32'd2, 32'd14}, stallreq low at T+33.
- Signed: op1=-7 (32'hFFFFFFF9), op2=2 -> quotient 32'hFFFFFFFD (-3), remainder 32'hFFFFFFFF (-1). Also op1=7, op2=-2 -> quotient -3, remainder 1.
- Divide-by-zero: op1=5, op2=0 -> ready at T+2, result_o=64'h0, stallreq high exactly T and T+1.
- Overflow edge: signed 32'h80000000 / 32'hFFFFFFFF -> result_o={32'h0, 32'h80000000}. Also unsigned 32'hFFFFFFFF / 1 -> quotient 32'hFFFFFFFF, remainder 0.
- Cancel: annul_i=1 at T+10 -> IDLE at T+11, ready_o never asserts, stallreq low from T+11. A subsequent start then completes normally.
- Reset mid-operation: rst=1 at T+5 -> state IDLE, ready_o=0, result_o=0, stallreq_for_ex=0 next cycle. Holding start_i=1 in END keeps ready_o=1 with the result stable until start_i drops.
